// File: rtl/beta_mem_wb_if.sv
// Data-memory request/acknowledge bus between the Beta mem stage and data memory.
interface beta_mem_wb_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/beta_mem_wb.sv
// Beta pipeline memory-access and write-back stages: data-memory handshake,
// mem/wb IR copies and bypass values, and the register-file write port.
module beta_mem_wb #(
  parameter logic [14:0] BUBBLE_IR = 15'h7C00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic [14:0]          ex_ir,
  input  logic [31:0]          ex_result,
  input  logic                 ex_is_load,
  input  logic                 ex_is_store,
  input  logic                 ex_writes_rc,
  input  logic [31:0]          ex_store_data,
  output logic                 ex_ready,
  beta_mem_wb_if.master        dmem,
  output logic [14:0]          ir_mem,
  output logic [14:0]          ir_wb,
  output logic                 op_ld_or_ldr_mem,
  output logic                 op_ld_or_ldr_wb,
  output logic [31:0]          mem_bypass,
  output logic [31:0]          wb_bypass,
  output logic                 we,
  output logic [4:0]           wa,
  output logic [31:0]          wd
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned IRW  = 15;
  localparam logic [4:0]  R31  = 5'd31;

  typedef enum logic {M_IDLE, M_WAIT} mstate_t;

  mstate_t           state_q, state_d;
  logic              m_valid, m_load, m_store;
  logic [IRW-1:0]    m_ir;
  logic [XLEN-1:0]   m_result, m_sdata;
  logic              w_valid, w_load;
  logic [IRW-1:0]    w_ir;
  logic [XLEN-1:0]   w_data;
  logic              m_access, mem_advance;

  assign m_access = m_valid & (m_load | m_store);

  // Access FSM state register: tracks whether a request is still outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= M_IDLE;
    else        state_q <= state_d;
  end

  // Access FSM next state plus memory request and stage-advance decode.
  always_comb begin
    state_d     = state_q;
    mem_advance = 1'b1;
    dmem.req    = 1'b0;
    dmem.we     = m_store;
    dmem.addr   = m_result;
    dmem.wdata  = m_sdata;
    if (m_access) begin
      dmem.req    = 1'b1;
      mem_advance = dmem.ack;
    end
    case (state_q)
      M_IDLE:  if (m_access && !dmem.ack) state_d = M_WAIT;
      M_WAIT:  if (!m_access || dmem.ack) state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  assign ex_ready = mem_advance;

  // Mem-stage capture from execute; holds while an access is waiting for ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_ir     <= BUBBLE_IR;
      m_result <= '0;
      m_load   <= 1'b0;
      m_store  <= 1'b0;
      m_sdata  <= '0;
    end else if (mem_advance) begin
      if (ex_valid) begin
        m_valid  <= 1'b1;
        // Non-writing ops get Rc=R31 so their Rc field never matches a source.
        m_ir     <= ex_writes_rc ? ex_ir : {R31, ex_ir[9:0]};
        m_result <= ex_result;
        m_load   <= ex_is_load;
        m_store  <= ex_is_store;
        m_sdata  <= ex_store_data;
      end else begin
        m_valid  <= 1'b0;
        m_ir     <= BUBBLE_IR;
        m_load   <= 1'b0;
        m_store  <= 1'b0;
      end
    end
  end

  // Write-back stage: takes the mem instruction when it retires, else a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_ir    <= BUBBLE_IR;
      w_load  <= 1'b0;
      w_data  <= '0;
    end else if (mem_advance && m_valid) begin
      w_valid <= 1'b1;
      w_ir    <= m_ir;
      w_load  <= m_load;
      w_data  <= m_load ? dmem.rdata : m_result;
    end else begin
      w_valid <= 1'b0;
      w_ir    <= BUBBLE_IR;
      w_load  <= 1'b0;
    end
  end

  assign ir_mem           = m_ir;
  assign op_ld_or_ldr_mem = m_valid & m_load;
  assign mem_bypass       = m_result;
  assign ir_wb            = w_ir;
  assign op_ld_or_ldr_wb  = w_load;
  assign wb_bypass        = w_data;
  assign wd               = w_data;
  assign wa               = w_ir[14:10];
  assign we               = w_valid && (w_ir[14:10] != R31);

endmodule

// File: tb/tb_beta_mem_wb.sv
// Self-checking bench for beta_mem_wb: directed cycle table, randomized
// scoreboard run, and asynchronous reset during an outstanding access.
module tb_beta_mem_wb;

  localparam logic [14:0] BUB = 15'h7C00;
  localparam logic [4:0]  R31 = 5'd31;
  localparam logic        T   = 1'b1;
  localparam logic        F   = 1'b0;
  localparam logic [31:0] Z   = 32'h0;

  typedef struct packed {
    logic        valid;
    logic [14:0] ir;
    logic [31:0] res;
    logic        ld;
    logic        st;
    logic        wrc;
    logic [31:0] sdata;
  } ex_t;

  typedef struct packed {
    ex_t         ex;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        req;
    logic        dwe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [14:0] irm;
    logic [14:0] irw;
    logic        ldm;
    logic        ldw;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        cmb;
    logic [31:0] mb;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_is_load, ex_is_store, ex_writes_rc, ex_ready;
  logic [14:0] ex_ir, ir_mem, ir_wb;
  logic [31:0] ex_result, ex_store_data, mem_bypass, wb_bypass, wd;
  logic        op_ld_or_ldr_mem, op_ld_or_ldr_wb, we;
  logic [4:0]  wa;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  beta_mem_wb_if dmem_bus ();

  beta_mem_wb #(.BUBBLE_IR(BUB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_ir            (ex_ir),
    .ex_result        (ex_result),
    .ex_is_load       (ex_is_load),
    .ex_is_store      (ex_is_store),
    .ex_writes_rc     (ex_writes_rc),
    .ex_store_data    (ex_store_data),
    .ex_ready         (ex_ready),
    .dmem             (dmem_bus),
    .ir_mem           (ir_mem),
    .ir_wb            (ir_wb),
    .op_ld_or_ldr_mem (op_ld_or_ldr_mem),
    .op_ld_or_ldr_wb  (op_ld_or_ldr_wb),
    .mem_bypass       (mem_bypass),
    .wb_bypass        (wb_bypass),
    .we               (we),
    .wa               (wa),
    .wd               (wd)
  );

  function automatic logic [14:0] irf(input logic [4:0] rc);
    return {rc, 5'd1, 5'd2};
  endfunction

  function automatic ex_t mkex(input logic v, input logic [4:0] rc, input logic [31:0] res,
                               input logic ld, input logic st, input logic wrc, input logic [31:0] sd);
    return '{v, irf(rc), res, ld, st, wrc, sd};
  endfunction

  // Memory contents as seen by the bench: a fixed scramble of the address.
  function automatic logic [31:0] rfun(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic ex_t rand_ex();
    ex_t e;
    int  kind;
    kind    = int'($urandom_range(0, 2));
    e.valid = ($urandom_range(0, 4) != 0);
    e.ir    = 15'($urandom);
    e.ld    = (kind == 1);
    e.st    = (kind == 2);
    e.res   = (kind == 0) ? $urandom : {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    e.wrc   = e.st ? 1'b0 : ($urandom_range(0, 9) != 0);
    e.sdata = $urandom;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_ex(input ex_t e);
    ex_valid      = e.valid;
    ex_ir         = e.ir;
    ex_result     = e.res;
    ex_is_load    = e.ld;
    ex_is_store   = e.st;
    ex_writes_rc  = e.wrc;
    ex_store_data = e.sdata;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " dmem_req"}, 32'(dmem_bus.req), 32'd0);
    chk({tag, " ex_ready"}, 32'(ex_ready), 32'd1);
    chk({tag, " ir_mem"}, 32'(ir_mem), 32'(BUB));
    chk({tag, " ir_wb"}, 32'(ir_wb), 32'(BUB));
    chk({tag, " ld_mem"}, 32'(op_ld_or_ldr_mem), 32'd0);
    chk({tag, " ld_wb"}, 32'(op_ld_or_ldr_wb), 32'd0);
    chk({tag, " we"}, 32'(we), 32'd0);
    chk({tag, " wa"}, 32'(wa), 32'd31);
    chk({tag, " wd"}, wd, 32'd0);
    chk({tag, " wb_bypass"}, wb_bypass, 32'd0);
    chk({tag, " mem_bypass"}, mem_bypass, 32'd0);
  endtask

  vec_t vecs [17];
  ex_t  nop, cur;
  acc_t acc_q [$];
  wr_t  wr_q [$];
  acc_t ea;
  wr_t  ew;
  bit   pend, adv, new_needed;
  logic ackv;

  initial begin
    nop = mkex(F, 5'd0, Z, F, F, F, Z);
    vecs[0]  = '{mkex(T, 5'd3, 32'h1234, F, F, T, Z), F, Z, T, F, F, Z, Z, BUB, BUB, F, F, F, R31, Z, F, Z};
    vecs[1]  = '{mkex(T, 5'd5, 32'h100, T, F, T, Z), F, Z, T, F, F, Z, Z, irf(3), BUB, F, F, F, R31, Z, T, 32'h1234};
    vecs[2]  = '{mkex(T, 5'd7, 32'h40, F, T, F, 32'hA5A5A5A5), F, Z, F, T, F, 32'h100, Z, irf(5), irf(3), T, F, T, 5'd3, 32'h1234, T, 32'h100};
    vecs[3]  = '{mkex(T, 5'd7, 32'h40, F, T, F, 32'hA5A5A5A5), F, Z, F, T, F, 32'h100, Z, irf(5), BUB, T, F, F, R31, Z, F, Z};
    vecs[4]  = '{mkex(T, 5'd7, 32'h40, F, T, F, 32'hA5A5A5A5), T, 32'hDEADBEEF, T, T, F, 32'h100, Z, irf(5), BUB, T, F, F, R31, Z, F, Z};
    vecs[5]  = '{mkex(T, 5'd31, 32'h99, F, F, T, Z), T, Z, T, T, T, 32'h40, 32'hA5A5A5A5, irf(31), irf(5), F, T, T, 5'd5, 32'hDEADBEEF, T, 32'h40};
    vecs[6]  = '{mkex(T, 5'd4, 32'h11, F, F, T, Z), F, Z, T, F, F, Z, Z, irf(31), irf(31), F, F, F, R31, Z, T, 32'h99};
    vecs[7]  = '{nop, F, Z, T, F, F, Z, Z, irf(4), irf(31), F, F, F, R31, Z, T, 32'h11};
    vecs[8]  = '{mkex(T, 5'd6, 32'h22, F, F, T, Z), F, Z, T, F, F, Z, Z, BUB, irf(4), F, F, T, 5'd4, 32'h11, F, Z};
    vecs[9]  = '{nop, F, Z, T, F, F, Z, Z, irf(6), BUB, F, F, F, R31, Z, T, 32'h22};
    vecs[10] = '{nop, F, Z, T, F, F, Z, Z, BUB, irf(6), F, F, T, 5'd6, 32'h22, F, Z};
    vecs[11] = '{nop, T, Z, T, F, F, Z, Z, BUB, BUB, F, F, F, R31, Z, F, Z};
    vecs[12] = '{mkex(T, 5'd8, 32'h200, T, F, T, Z), F, Z, T, F, F, Z, Z, BUB, BUB, F, F, F, R31, Z, F, Z};
    vecs[13] = '{mkex(T, 5'd9, 32'h200, T, F, T, Z), T, 32'h1, T, T, F, 32'h200, Z, irf(8), BUB, T, F, F, R31, Z, T, 32'h200};
    vecs[14] = '{nop, T, 32'h2, T, T, F, 32'h200, Z, irf(9), irf(8), T, T, T, 5'd8, 32'h1, T, 32'h200};
    vecs[15] = '{nop, F, Z, T, F, F, Z, Z, BUB, irf(9), F, T, T, 5'd9, 32'h2, F, Z};
    vecs[16] = '{nop, F, Z, T, F, F, Z, Z, BUB, BUB, F, F, F, R31, Z, F, Z};

    drive_ex(nop);
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 32'h0;

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed cycle table.
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      drive_ex(vecs[i].ex);
      dmem_bus.ack   = vecs[i].ack;
      dmem_bus.rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d ex_ready", i), 32'(ex_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d dmem_req", i), 32'(dmem_bus.req), 32'(vecs[i].req));
      if (vecs[i].req) begin
        chk($sformatf("v%0d dmem_we", i), 32'(dmem_bus.we), 32'(vecs[i].dwe));
        chk($sformatf("v%0d dmem_addr", i), dmem_bus.addr, vecs[i].addr);
        chk($sformatf("v%0d dmem_wdata", i), dmem_bus.wdata, vecs[i].wdata);
      end
      chk($sformatf("v%0d ir_mem", i), 32'(ir_mem), 32'(vecs[i].irm));
      chk($sformatf("v%0d ir_wb", i), 32'(ir_wb), 32'(vecs[i].irw));
      chk($sformatf("v%0d ld_mem", i), 32'(op_ld_or_ldr_mem), 32'(vecs[i].ldm));
      chk($sformatf("v%0d ld_wb", i), 32'(op_ld_or_ldr_wb), 32'(vecs[i].ldw));
      chk($sformatf("v%0d we", i), 32'(we), 32'(vecs[i].we));
      chk($sformatf("v%0d wa", i), 32'(wa), 32'(vecs[i].wa));
      if (vecs[i].we) begin
        chk($sformatf("v%0d wd", i), wd, vecs[i].wd);
        chk($sformatf("v%0d wb_bypass", i), wb_bypass, vecs[i].wd);
      end
      if (vecs[i].cmb) chk($sformatf("v%0d mem_bypass", i), mem_bypass, vecs[i].mb);
    end

    // Randomized run against an in-order scoreboard of accesses and writes.
    pend       = 1'b0;
    new_needed = 1'b1;
    cur        = nop;
    for (int cy = 0; cy < 640; cy++) begin
      @(posedge clk); #1;
      if (new_needed) cur = (cy >= 600) ? nop : rand_ex();
      ackv = (cy >= 600) ? 1'b1 : ($urandom_range(0, 1) == 1);
      drive_ex(cur);
      dmem_bus.ack   = ackv;
      dmem_bus.rdata = rfun(dmem_bus.addr);
      @(negedge clk);
      chk($sformatf("r%0d dmem_req", cy), 32'(dmem_bus.req), 32'(pend));
      chk($sformatf("r%0d ex_ready", cy), 32'(ex_ready), 32'(!pend || ackv));
      if (pend && ackv) begin
        if (acc_q.size() == 0) chk($sformatf("r%0d unexpected access", cy), 32'd1, 32'd0);
        else begin
          ea = acc_q.pop_front();
          chk($sformatf("r%0d dmem_we", cy), 32'(dmem_bus.we), 32'(ea.we));
          chk($sformatf("r%0d dmem_addr", cy), dmem_bus.addr, ea.addr);
          if (ea.we) chk($sformatf("r%0d dmem_wdata", cy), dmem_bus.wdata, ea.wdata);
        end
      end
      if (we) begin
        if (wr_q.size() == 0) chk($sformatf("r%0d unexpected write wa", cy), 32'(wa), 32'd31);
        else begin
          ew = wr_q.pop_front();
          chk($sformatf("r%0d wa", cy), 32'(wa), 32'(ew.wa));
          chk($sformatf("r%0d wd", cy), wd, ew.wd);
        end
      end
      adv = !pend || ackv;
      if (adv) begin
        if (cur.valid) begin
          if (cur.ld || cur.st) acc_q.push_back('{cur.st, cur.res, cur.sdata});
          if (cur.wrc && cur.ir[14:10] != R31)
            wr_q.push_back('{cur.ir[14:10], cur.ld ? rfun(cur.res) : cur.res});
        end
        pend = cur.valid && (cur.ld || cur.st);
      end
      new_needed = adv;
    end
    chk("pending accesses after drain", 32'(acc_q.size()), 32'd0);
    chk("pending writes after drain", 32'(wr_q.size()), 32'd0);

    // Asynchronous reset while a load is waiting for its ack.
    @(posedge clk); #1;
    drive_ex(mkex(T, 5'd10, 32'h300, T, F, T, Z));
    dmem_bus.ack = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset dmem_req", 32'(dmem_bus.req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("mid-reset");
    drive_ex(nop);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset we", 32'(we), 32'd0);
    chk("post-reset dmem_req", 32'(dmem_bus.req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
